// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron row sequencer:
//   - default geometry / latency values for the sequencer and its tag pipe
//   - the sequencer state enumeration
// Optional feature macro used by files importing this package:
//   NEURON_SEQ_STALL_EN - adds a stall input that pauses row issue.
// ---------------------------------------------------------------------------
package neuron_pkg;

    // Partial-product rows accumulated per neuron pass.
    localparam int NSEQ_ROWS    = 28;
    // Width of the weight/pixel row selects.
    localparam int NSEQ_SEL_W   = 5;
    // Cycles from a row select being presented to that row's sum being valid
    // (one multiplier stage plus five adder stages).
    localparam int NSEQ_ROW_LAT = 6;
    // Cycles from the last row-register enable to the final sum being valid.
    localparam int NSEQ_SUM_LAT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FINAL = 2'd3
    } seq_state_t;

endpackage

// File: rtl/neuron_sequencer_if.sv
// ---------------------------------------------------------------------------
// neuron_sequencer_if
// Control/handshake bundle between a pass requester and the neuron sequencer.
//   start          : request one neuron pass (requester -> sequencer)
//   stall          : pause row issue, only with NEURON_SEQ_STALL_EN
//   busy           : pass in progress
//   done           : one-cycle pulse, final neuron output valid
//   WeightX_Select : weight row select
//   PixelX_Select  : pixel row select
//   ENX_Int        : one-hot row-register enable
//   ENX            : final output-register enable
// Modports: master (requester side), slave (sequencer side).
// Optional feature macro: NEURON_SEQ_STALL_EN.
// ---------------------------------------------------------------------------
interface neuron_sequencer_if
    import neuron_pkg::*;
#(
    parameter int ROWS  = NSEQ_ROWS,
    parameter int SEL_W = NSEQ_SEL_W
);

    logic             start;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] WeightX_Select;
    logic [SEL_W-1:0] PixelX_Select;
    logic [ROWS-1:0]  ENX_Int;
    logic             ENX;

`ifdef NEURON_SEQ_STALL_EN
    logic             stall;

    modport master (
        output start,
        output stall,
        input  busy,
        input  done,
        input  WeightX_Select,
        input  PixelX_Select,
        input  ENX_Int,
        input  ENX
    );

    modport slave (
        input  start,
        input  stall,
        output busy,
        output done,
        output WeightX_Select,
        output PixelX_Select,
        output ENX_Int,
        output ENX
    );
`else
    modport master (
        output start,
        input  busy,
        input  done,
        input  WeightX_Select,
        input  PixelX_Select,
        input  ENX_Int,
        input  ENX
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output WeightX_Select,
        output PixelX_Select,
        output ENX_Int,
        output ENX
    );
`endif

endinterface

// File: rtl/nseq_tag_pipe.sv
// ---------------------------------------------------------------------------
// nseq_tag_pipe
// ROW_LAT-deep delay line carrying {valid, row} alongside the multiply/add
// datapath, so the sequencer knows which row register to enable when a row
// sum emerges.
// Ports:
//   clk         : clock
//   GlobalReset : asynchronous active-high reset, empties the pipe
//   in_valid    : a row was issued this cycle (0 = bubble)
//   in_row      : row number of the issued row
//   out_valid   : a row tag is exiting this cycle
//   out_row     : row number of the exiting tag
// ---------------------------------------------------------------------------
module nseq_tag_pipe
    import neuron_pkg::*;
#(
    parameter int SEL_W   = NSEQ_SEL_W,
    parameter int ROW_LAT = NSEQ_ROW_LAT
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_row,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_row
);

    logic [ROW_LAT-1:0] valid_q;
    logic [SEL_W-1:0]   row_q [ROW_LAT];

    // Plain shift register; stage 0 captures the issue-cycle tag and the last
    // stage is what the sequencer decodes ROW_LAT cycles later.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            valid_q <= '0;
            for (int i = 0; i < ROW_LAT; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            row_q[0]   <= in_row;
            for (int i = 1; i < ROW_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                row_q[i]   <= row_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[ROW_LAT-1];
    assign out_row   = row_q[ROW_LAT-1];

endmodule

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
// Sequences one neuron pass: issues ROWS row selects to the multiply/add
// datapath, enables each row register as its sum emerges, then enables the
// final output register once the row sums have been reduced.
// Ports:
//   clk         : the only clock
//   GlobalReset : asynchronous active-high reset, aborts any pass
//   bus         : neuron_sequencer_if slave (start, busy, done, selects,
//                 ENX_Int, ENX and optionally stall)
// Optional feature macro:
//   NEURON_SEQ_STALL_EN - stall input holds the row counter and selects
//                         during ISSUE; the tag pipe and drain keep running.
// ---------------------------------------------------------------------------
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int ROWS    = NSEQ_ROWS,
    parameter int SEL_W   = NSEQ_SEL_W,
    parameter int ROW_LAT = NSEQ_ROW_LAT,
    parameter int SUM_LAT = NSEQ_SUM_LAT
) (
    input  logic              clk,
    input  logic              GlobalReset,
    neuron_sequencer_if.slave bus
);

    localparam int CNT_W  = (ROWS > 1)    ? $clog2(ROWS)    : 1;
    localparam int DCNT_W = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;

    localparam logic [CNT_W-1:0]  LAST_ROW   = CNT_W'(ROWS - 1);
    localparam logic [SEL_W-1:0]  LAST_TAG   = SEL_W'(ROWS - 1);
    localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(SUM_LAT - 1);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [CNT_W-1:0]  row_cnt_q;
    logic [DCNT_W-1:0] drain_cnt_q;
    logic              row_held_q;
    logic              done_q;

    logic              stall_i;
    logic [SEL_W-1:0]  row_sel;
    logic              inject;
    logic              tag_valid;
    logic [SEL_W-1:0]  tag_row;
    logic              last_exit;
    logic              drain_active;
    logic              drain_hit;
    logic [ROWS-1:0]   row_en;

`ifdef NEURON_SEQ_STALL_EN
    assign stall_i = bus.stall;
`else
    assign stall_i = 1'b0;
`endif

    assign row_sel = (state_q == ISSUE) ? SEL_W'(row_cnt_q) : '0;

    // A row's tag enters the pipe on the first cycle that row is presented.
    // Cycles where the previous cycle was stalled re-present the same row and
    // only push bubbles, so each row is enabled exactly once.
    assign inject = (state_q == ISSUE) && !row_held_q;

    nseq_tag_pipe #(
        .SEL_W   (SEL_W),
        .ROW_LAT (ROW_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_valid    (inject),
        .in_row      (row_sel),
        .out_valid   (tag_valid),
        .out_row     (tag_row)
    );

    // Decode the exiting tag into the one-hot row-register enable.
    always_comb begin
        row_en = '0;
        for (int i = 0; i < ROWS; i++) begin
            row_en[i] = tag_valid && (tag_row == SEL_W'(i));
        end
    end

    // The drain window opens on the cycle the last row's tag exits and lasts
    // SUM_LAT cycles, so FINAL lands exactly SUM_LAT cycles after that exit.
    assign last_exit    = tag_valid && (tag_row == LAST_TAG);
    assign drain_active = last_exit || (drain_cnt_q != '0);
    assign drain_hit    = (state_q == DRAIN) && drain_active
                          && (drain_cnt_q == LAST_DRAIN);

    // State register.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall_i && (row_cnt_q == LAST_ROW)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_hit) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row counter, stall-hold flag, drain counter and the done pulse.
    // The row counter is forced back to 0 outside ISSUE so it never wraps.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            row_cnt_q   <= '0;
            row_held_q  <= 1'b0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                if (!stall_i) begin
                    row_cnt_q <= (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
                end
            end else begin
                row_cnt_q <= '0;
            end

            row_held_q <= (state_q == ISSUE) && stall_i;

            if ((state_q == DRAIN) && drain_active && !drain_hit) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end else begin
                drain_cnt_q <= '0;
            end

            done_q <= (state_q == FINAL);
        end
    end

    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.WeightX_Select = row_sel;
    assign bus.PixelX_Select  = row_sel;
    assign bus.ENX_Int        = row_en;
    assign bus.ENX            = (state_q == FINAL);

endmodule

// File: tb/tb_neuron_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_sequencer
// Self-checking bench for neuron_sequencer. Two instances run side by side:
//   dut_a : default geometry (ROWS=28, SEL_W=5, ROW_LAT=6, SUM_LAT=5)
//   dut_b : minimal geometry (ROWS=4,  SEL_W=2, ROW_LAT=1, SUM_LAT=1)
// An event-level model (pass acceptance, per-row exit times, ENX time) is
// compared against both instances every cycle, and literal expectations at
// key cycles pin the model. Stall scenarios need NEURON_SEQ_STALL_EN.
// ---------------------------------------------------------------------------
module tb_neuron_sequencer;

    logic clk;
    logic rst;
    int   cyc;
    int   base;
    int   total;
    int   bad;

    neuron_sequencer_if #(.ROWS(28), .SEL_W(5)) bus_a ();
    neuron_sequencer_if #(.ROWS(4),  .SEL_W(2)) bus_b ();

    neuron_sequencer #(
        .ROWS(28), .SEL_W(5), .ROW_LAT(6), .SUM_LAT(5)
    ) dut_a (
        .clk         (clk),
        .GlobalReset (rst),
        .bus         (bus_a)
    );

    neuron_sequencer #(
        .ROWS(4), .SEL_W(2), .ROW_LAT(1), .SUM_LAT(1)
    ) dut_b (
        .clk         (clk),
        .GlobalReset (rst),
        .bus         (bus_b)
    );

    logic stall_a;
    logic stall_b;
`ifdef NEURON_SEQ_STALL_EN
    assign stall_a = bus_a.stall;
    assign stall_b = bus_b.stall;
`else
    assign stall_a = 1'b0;
    assign stall_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: per-instance geometry and pass state, plus a table of
    // (instance, cycle) -> row whose row-register enable fires then.
    int m_rows [2] = '{28, 4};
    int m_rl   [2] = '{6, 1};
    int m_sl   [2] = '{5, 1};
    bit m_busy [2];
    bit m_issue[2];
    bit m_fresh[2];
    int m_row  [2];
    int m_enx_at[2] = '{-10, -10};
    int exit_row[int];

    task automatic check_val(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                     name, k, cyc - base, act, exp);
        end
    endtask

    task automatic compare_dut(input int k, input logic busy, input logic done,
                               input logic [31:0] wsel, input logic [31:0] psel,
                               input logic [31:0] enx_int, input logic enx,
                               input logic start, input logic stall);
        int          key;
        logic [31:0] exp_sel;
        logic [31:0] exp_int;
        if (rst) begin
            check_val("rst_busy", k, 32'(busy), 32'd0);
            check_val("rst_done", k, 32'(done), 32'd0);
            check_val("rst_wsel", k, wsel, 32'd0);
            check_val("rst_psel", k, psel, 32'd0);
            check_val("rst_enx_int", k, enx_int, 32'd0);
            check_val("rst_enx", k, 32'(enx), 32'd0);
            exit_row.delete();
            m_busy[k]   = 1'b0;
            m_issue[k]  = 1'b0;
            m_fresh[k]  = 1'b0;
            m_row[k]    = 0;
            m_enx_at[k] = -10;
            return;
        end
        key     = k * 1000000 + cyc;
        exp_sel = m_issue[k] ? 32'(m_row[k]) : 32'd0;
        exp_int = exit_row.exists(key) ? (32'd1 << exit_row[key]) : 32'd0;
        check_val("busy", k, 32'(busy), 32'(m_busy[k]));
        check_val("done", k, 32'(done), 32'(cyc == m_enx_at[k] + 1));
        check_val("wsel", k, wsel, exp_sel);
        check_val("psel", k, psel, exp_sel);
        check_val("enx_int", k, enx_int, exp_int);
        check_val("enx", k, 32'(enx), 32'(cyc == m_enx_at[k]));

        // Advance the model to the next cycle.
        if (!m_busy[k]) begin
            if (start) begin
                m_busy[k]  = 1'b1;
                m_issue[k] = 1'b1;
                m_row[k]   = 0;
                m_fresh[k] = 1'b1;
            end
        end else begin
            if (m_issue[k]) begin
                if (m_fresh[k]) begin
                    exit_row[k * 1000000 + cyc + m_rl[k]] = m_row[k];
                    if (m_row[k] == m_rows[k] - 1) begin
                        m_enx_at[k] = cyc + m_rl[k] + m_sl[k];
                    end
                end
                if (!stall) begin
                    if (m_row[k] == m_rows[k] - 1) m_issue[k] = 1'b0;
                    else                           m_row[k]++;
                    m_fresh[k] = 1'b1;
                end else begin
                    m_fresh[k] = 1'b0;
                end
            end
            if (cyc == m_enx_at[k]) m_busy[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        compare_dut(0, bus_a.busy, bus_a.done, 32'(bus_a.WeightX_Select),
                    32'(bus_a.PixelX_Select), 32'(bus_a.ENX_Int), bus_a.ENX,
                    bus_a.start, stall_a);
        compare_dut(1, bus_b.busy, bus_b.done, 32'(bus_b.WeightX_Select),
                    32'(bus_b.PixelX_Select), 32'(bus_b.ENX_Int), bus_b.ENX,
                    bus_b.start, stall_b);
    end

    // Advance to test-relative cycle t, landing just after its rising edge.
    task automatic goto_cycle(input int t);
        while (cyc < base + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        check_val(name, k, act, exp);
    endtask

    task automatic apply_stimulus();
        // Reset state.
        base = 0;
        goto_cycle(3);
        check_output("lit_rst_busy", 0, 32'(bus_a.busy), 32'd0);
        check_output("lit_rst_enx_int", 0, 32'(bus_a.ENX_Int), 32'd0);
        rst = 1'b0;
        goto_cycle(5);

        // Single pass on both instances.
        $display("[TB] single pass");
        base = cyc;
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        goto_cycle(1);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check_output("lit_a_busy1", 0, 32'(bus_a.busy), 32'd1);
        check_output("lit_a_sel1", 0, 32'(bus_a.WeightX_Select), 32'd0);
        goto_cycle(2);
        check_output("lit_b_int2", 1, 32'(bus_b.ENX_Int), 32'h1);
        goto_cycle(5);
        check_output("lit_b_int5", 1, 32'(bus_b.ENX_Int), 32'h8);
        goto_cycle(6);
        check_output("lit_b_enx6", 1, 32'(bus_b.ENX), 32'd1);
        goto_cycle(7);
        check_output("lit_a_int7", 0, 32'(bus_a.ENX_Int), 32'h1);
        check_output("lit_b_done7", 1, 32'(bus_b.done), 32'd1);
        goto_cycle(28);
        check_output("lit_a_wsel28", 0, 32'(bus_a.WeightX_Select), 32'd27);
        check_output("lit_a_psel28", 0, 32'(bus_a.PixelX_Select), 32'd27);
        goto_cycle(29);
        check_output("lit_a_wsel29", 0, 32'(bus_a.WeightX_Select), 32'd0);
        goto_cycle(34);
        check_output("lit_a_int34", 0, 32'(bus_a.ENX_Int), 32'h0800_0000);
        goto_cycle(39);
        check_output("lit_a_enx39", 0, 32'(bus_a.ENX), 32'd1);
        check_output("lit_a_busy39", 0, 32'(bus_a.busy), 32'd1);
        goto_cycle(40);
        check_output("lit_a_done40", 0, 32'(bus_a.done), 32'd1);
        check_output("lit_a_busy40", 0, 32'(bus_a.busy), 32'd0);
        goto_cycle(45);

        // Start held high: back-to-back passes.
        $display("[TB] start held");
        base = cyc;
        bus_a.start = 1'b1;
        goto_cycle(39);
        check_output("lit_b2b_enx39", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(40);
        check_output("lit_b2b_done40", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(41);
        check_output("lit_b2b_busy41", 0, 32'(bus_a.busy), 32'd1);
        goto_cycle(47);
        check_output("lit_b2b_int47", 0, 32'(bus_a.ENX_Int), 32'h1);
        goto_cycle(79);
        check_output("lit_b2b_enx79", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(80);
        check_output("lit_b2b_done80", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(81);
        bus_a.start = 1'b0;
        goto_cycle(119);
        check_output("lit_b2b_enx119", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(120);
        check_output("lit_b2b_done120", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(121);
        check_output("lit_b2b_busy121", 0, 32'(bus_a.busy), 32'd0);
        goto_cycle(130);

        // Start during ISSUE is ignored.
        $display("[TB] start during issue");
        base = cyc;
        bus_a.start = 1'b1;
        goto_cycle(1);
        bus_a.start = 1'b0;
        goto_cycle(15);
        bus_a.start = 1'b1;
        goto_cycle(16);
        bus_a.start = 1'b0;
        goto_cycle(39);
        check_output("lit_ign_enx39", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(40);
        check_output("lit_ign_done40", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(41);
        check_output("lit_ign_busy41", 0, 32'(bus_a.busy), 32'd0);
        goto_cycle(90);

        // Reset mid-pass.
        $display("[TB] reset mid-pass");
        base = cyc;
        bus_a.start = 1'b1;
        goto_cycle(1);
        bus_a.start = 1'b0;
        goto_cycle(18);
        bus_b.start = 1'b1;
        goto_cycle(19);
        bus_b.start = 1'b0;
        goto_cycle(20);
        rst = 1'b1;
        #1;
        check_output("lit_rst_busy20", 0, 32'(bus_a.busy), 32'd0);
        check_output("lit_rst_wsel20", 0, 32'(bus_a.WeightX_Select), 32'd0);
        check_output("lit_rst_b_busy20", 1, 32'(bus_b.busy), 32'd0);
        goto_cycle(22);
        rst = 1'b0;
        goto_cycle(24);
        check_output("lit_rst_b_enx24", 1, 32'(bus_b.ENX), 32'd0);
        goto_cycle(30);
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        goto_cycle(31);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        goto_cycle(36);
        check_output("lit_rst_b_enx36", 1, 32'(bus_b.ENX), 32'd1);
        goto_cycle(37);
        check_output("lit_rst_int37", 0, 32'(bus_a.ENX_Int), 32'h1);
        check_output("lit_rst_b_done37", 1, 32'(bus_b.done), 32'd1);
        goto_cycle(39);
        check_output("lit_rst_enx39", 0, 32'(bus_a.ENX), 32'd0);
        goto_cycle(40);
        check_output("lit_rst_done40", 0, 32'(bus_a.done), 32'd0);
        goto_cycle(69);
        check_output("lit_rst_enx69", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(70);
        check_output("lit_rst_done70", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(75);

`ifdef NEURON_SEQ_STALL_EN
        // Stall for three cycles mid-issue.
        $display("[TB] stall");
        base = cyc;
        bus_a.start = 1'b1;
        goto_cycle(1);
        bus_a.start = 1'b0;
        goto_cycle(5);
        bus_a.stall = 1'b1;
        check_output("lit_stl_wsel5", 0, 32'(bus_a.WeightX_Select), 32'd4);
        goto_cycle(8);
        bus_a.stall = 1'b0;
        check_output("lit_stl_wsel8", 0, 32'(bus_a.WeightX_Select), 32'd4);
        goto_cycle(9);
        check_output("lit_stl_wsel9", 0, 32'(bus_a.WeightX_Select), 32'd5);
        goto_cycle(11);
        check_output("lit_stl_int11", 0, 32'(bus_a.ENX_Int), 32'h10);
        goto_cycle(15);
        check_output("lit_stl_int15", 0, 32'(bus_a.ENX_Int), 32'h20);
        goto_cycle(42);
        check_output("lit_stl_enx42", 0, 32'(bus_a.ENX), 32'd1);
        goto_cycle(43);
        check_output("lit_stl_done43", 0, 32'(bus_a.done), 32'd1);
        goto_cycle(50);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        base  = 0;
        rst   = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
`ifdef NEURON_SEQ_STALL_EN
        bus_a.stall = 1'b0;
        bus_b.stall = 1'b0;
`endif
        apply_stimulus();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter ROWS, default 28, meaning partial-product rows per neuron pass.
REQ-002 Parameter SEL_W, default 5, meaning row-select width.
REQ-003 Parameter ROW_LAT, default 6, meaning cycles from select presented to row sum valid (1 mult + 5 adder).
REQ-004 Parameter SUM_LAT, default 5, meaning cycles from last row-register enable to final sum valid.
REQ-005 Ports SHALL be as follows.
- clk, input, 1: the only clock.
- GlobalReset, input, 1: asynchronous, active-high reset.
- start, input, 1: request one neuron pass.
- busy, output, 1: pass in progress.
- done, output, 1: one-cycle pulse; Out_X is valid.
- WeightX_Select, output, SEL_W: weight row select.
- PixelX_Select, output, SEL_W: pixel row select.
- ENX_Int, output, ROWS: one-hot row-register enable.
- ENX, output, 1: final output-register enable.
- stall, input, 1: present only under NEURON_SEQ_STALL_EN; pauses issue.

Function
REQ-006 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and FINAL.
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN after row ROWS-1 is issued.
- DRAIN -> FINAL when the last row tag has exited and SUM_LAT cycles have elapsed.
- FINAL -> IDLE after one cycle.
REQ-007 start SHALL be sampled only in IDLE; start in any other state is ignored, with no queuing.
REQ-008 In ISSUE, WeightX_Select and PixelX_Select SHALL both equal the row counter r, which runs 0..ROWS-1 and advances one row per non-stalled cycle.
REQ-009 Outside ISSUE, both selects SHALL be 0.
REQ-010 Each issued row SHALL inject {valid, r} into a ROW_LAT-deep tag pipe; stalled cycles inject bubbles.
REQ-011 ENX_Int[r] SHALL be high for exactly one cycle when the tag for row r exits the pipe; all other bits are 0 in that cycle.
REQ-012 ENX_Int SHALL be all-zero in every cycle in which no valid tag exits.
REQ-013 ENX SHALL be high for exactly one cycle, SUM_LAT cycles after the ENX_Int[ROWS-1] cycle; this is the FINAL state.
REQ-014 done SHALL pulse in the cycle after ENX.
REQ-015 busy SHALL be high from the cycle after start is accepted through the ENX cycle inclusive.
REQ-016 A start asserted in the done cycle SHALL be accepted, giving back-to-back passes with no idle gap.
REQ-017 With stall never asserted and start accepted at cycle 0, timing SHALL be:
- ISSUE spans cycles 1..ROWS.
- ENX_Int[r] fires at cycle 1+r+ROW_LAT.
- ENX fires at cycle ROWS+ROW_LAT+SUM_LAT.
- done fires one cycle later.
- With defaults: ENX_Int[0]@7, ENX_Int[27]@34, ENX@39, done@40.
REQ-018 The row counter SHALL be ceil(log2(ROWS)) bits and SHALL never wrap past ROWS-1.
REQ-019 The drain counter SHALL count 0..SUM_LAT-1 and then clear.

Reset
REQ-020 While GlobalReset is high, the FSM SHALL be in IDLE and all outputs 0: busy, done, both selects, ENX_Int and ENX.
REQ-021 The tag pipe and all counters SHALL be cleared by GlobalReset.
REQ-022 A reset mid-pass SHALL abort the pass with no ENX and no done afterward; the first post-reset start SHALL begin a clean pass.

Configuration
REQ-023 Macro NEURON_SEQ_STALL_EN SHALL control the stall feature.
- Defined: the stall port exists. While stall=1 in ISSUE, the row counter and selects hold and a bubble is injected into the tag pipe.
- Defined: the tag pipe, DRAIN, FINAL and done are unaffected by stall.
- Undefined: no stall port; the block behaves as with stall tied 0.

Structure
REQ-024 Package neuron_pkg SHALL hold ROWS, SEL_W, ROW_LAT and SUM_LAT defaults plus the state enum (IDLE/ISSUE/DRAIN/FINAL).
REQ-025 Sub-module nseq_tag_pipe SHALL implement the ROW_LAT-deep {valid, row} delay line with asynchronous reset.

Verification
REQ-026 Single pass with defaults, start@0: selects 0..27 on cycles 1..28; ENX_Int one-hot bit r at cycle 7+r; ENX@39; done@40; busy high on cycles 1..39.
REQ-027 start held high continuously: passes start on cycles 0, 40 and 80; each pass repeats the REQ-026 timing, with no extra ENX pulses.
REQ-028 start pulsed at cycle 15 during ISSUE: ignored; exactly one ENX@39 and one done@40.
REQ-029 GlobalReset asserted at cycle 20 for 2 cycles: all outputs 0 at once; no ENX or done follow; a new start@30 gives ENX@69 and done@70.
REQ-030 With NEURON_SEQ_STALL_EN, stall=1 on cycles 5..7: selects hold 4 on cycles 5..8; ENX_Int[4]@11, ENX_Int[5]@15; ENX@42; done@43.
REQ-031 ROW_LAT=1, SUM_LAT=1, ROWS=4: ENX_Int bits 0..3 on cycles 2..5; ENX@6; done@7.
